// File: rtl/fetch_issue_ctrl_if.sv
// Fetch/issue bus of fetch_issue_ctrl: instruction-memory handshake, issue port,
// execute redirect and halt status, grouped so the sequencer and its environment share one bundle.
interface fetch_issue_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        illegal;

    modport master (
        output imem_req, imem_addr, issue_valid, issue_instr, issue_pc, halted, illegal,
        input  imem_ack, imem_rdata, issue_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, issue_valid, issue_instr, issue_pc, halted, illegal,
        output imem_ack, imem_rdata, issue_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_issue_ctrl.sv
// Multi-cycle RV32I fetch/decode sequencer: owns the PC, runs the imem handshake,
// screens opcodes and presents each instruction on a valid/ready issue port.
module fetch_issue_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_issue_ctrl_if.master   bus
);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] ipc_r;
    logic [31:0] rpc_r;
    logic        drop_r;
    logic        illegal_r;
    logic [31:0] target_s;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: is_legal_op = 1'b1;
            default:                                         is_legal_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_system_op(input logic [6:0] op);
        is_system_op = (op == 7'b1110011);
    endfunction

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign target_s = bus.redirect_pc & 32'hFFFF_FFFC;

    assign bus.imem_req    = (state_r == ST_FETCH);
    assign bus.imem_addr   = pc_r;
    assign bus.issue_valid = (state_r == ST_ISSUE);
    assign bus.issue_instr = ir_r;
    assign bus.issue_pc    = ipc_r;
    assign bus.halted      = (state_r == ST_HALT);
    assign bus.illegal     = illegal_r;

    // Sequencer state, PC and instruction latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_BOOT;
            pc_r      <= RESET_PC;
            ir_r      <= 32'h0000_0000;
            ipc_r     <= 32'h0000_0000;
            rpc_r     <= 32'h0000_0000;
            drop_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        // A same-cycle redirect is newer than any pending drop target.
                        if (bus.redirect_valid) begin
                            pc_r   <= target_s;
                            drop_r <= 1'b0;
                        end else if (drop_r) begin
                            pc_r   <= rpc_r;
                            drop_r <= 1'b0;
                        end else begin
                            ir_r    <= bus.imem_rdata;
                            ipc_r   <= pc_r;
                            state_r <= ST_DECODE;
                        end
                    end else if (bus.redirect_valid) begin
                        // Request in flight: keep imem_addr stable, retarget after its ack.
                        drop_r <= 1'b1;
                        rpc_r  <= target_s;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (bus.redirect_valid) begin
                        pc_r    <= target_s;
                        state_r <= ST_FETCH;
                    end else if (ir_r[1:0] == 2'b11 && is_legal_op(ir_r[6:0])) begin
                        state_r <= ST_ISSUE;
                    end else begin
                        illegal_r <= !is_system_op(ir_r[6:0]);
                        state_r   <= ST_HALT;
                    end
                end
                ST_ISSUE: begin
                    if (bus.redirect_valid) begin
                        pc_r    <= target_s;
                        state_r <= ST_FETCH;
                    end else if (bus.issue_ready) begin
                        pc_r    <= ipc_r + 32'd4;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl: a per-cycle vector table plus hand sequences
// for PC wrap, asynchronous reset with a late ack, and illegal-instruction halt.
module tb_fetch_issue_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] W0  = 32'h0010_0093;
    localparam logic [31:0] W1  = 32'h0020_0113;
    localparam logic [31:0] W2  = 32'h0030_0193;
    localparam logic [31:0] BAD = 32'hFFFF_FFFF;
    localparam logic [31:0] EC  = 32'h0000_0073;

    logic clk;
    logic rst_n;
    fetch_issue_ctrl_if bus();

    fetch_issue_ctrl #(.RESET_PC(RPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        halted;
        logic        illegal;
    } vec_t;

    vec_t vq[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic vec_t v(input logic ack, input logic [31:0] rdata, input logic ready,
                               input logic rv, input logic [31:0] rpc, input logic req,
                               input logic [31:0] addr, input logic valid, input logic [31:0] instr,
                               input logic [31:0] ipc, input logic halted, input logic illegal);
        vec_t r;
        r.ack = ack; r.rdata = rdata; r.ready = ready; r.rv = rv; r.rpc = rpc;
        r.req = req; r.addr = addr; r.valid = valid; r.instr = instr; r.ipc = ipc;
        r.halted = halted; r.illegal = illegal;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] instr, input logic [31:0] ipc,
                           input logic halted, input logic illegal);
        chk({tag, "_req"},     {31'd0, bus.imem_req},    {31'd0, req});
        chk({tag, "_addr"},    bus.imem_addr,            addr);
        chk({tag, "_valid"},   {31'd0, bus.issue_valid}, {31'd0, valid});
        chk({tag, "_instr"},   bus.issue_instr,          instr);
        chk({tag, "_pc"},      bus.issue_pc,             ipc);
        chk({tag, "_halted"},  {31'd0, bus.halted},      {31'd0, halted});
        chk({tag, "_illegal"}, {31'd0, bus.illegal},     {31'd0, illegal});
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                         input logic rv, input logic [31:0] rpc);
        bus.imem_ack       = ack;
        bus.imem_rdata     = rdata;
        bus.issue_ready    = ready;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.issue_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;

        // Each row: outputs seen in this cycle, then inputs applied for its closing edge.
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b0, 32'd0,        1'b0, RPC,           1'b0, 32'd0, 32'd0,         1'b0, 1'b0)); // BOOT
        vq.push_back(v(1'b1, W0,    1'b1, 1'b0, 32'd0,        1'b1, RPC,           1'b0, 32'd0, 32'd0,         1'b0, 1'b0)); // FETCH 100
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b0, 32'd0,        1'b0, RPC,           1'b0, W0,    RPC,           1'b0, 1'b0)); // DECODE
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b0, 32'd0,        1'b0, RPC,           1'b1, W0,    RPC,           1'b0, 1'b0)); // ISSUE
        vq.push_back(v(1'b1, W1,    1'b1, 1'b0, 32'd0,        1'b1, 32'h104,       1'b0, W0,    RPC,           1'b0, 1'b0)); // FETCH 104
        vq.push_back(v(1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b0, 32'h104,       1'b0, W1,    32'h104,       1'b0, 1'b0));
        for (int k = 0; k < 5; k++)
            vq.push_back(v(1'b0, 32'd0, 1'b0, 1'b0, 32'd0,    1'b0, 32'h104,       1'b1, W1,    32'h104,       1'b0, 1'b0)); // stalled
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b0, 32'd0,        1'b0, 32'h104,       1'b1, W1,    32'h104,       1'b0, 1'b0)); // ready rises
        vq.push_back(v(1'b1, W2,    1'b1, 1'b0, 32'd0,        1'b1, 32'h108,       1'b0, W1,    32'h104,       1'b0, 1'b0));
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b0, 32'd0,        1'b0, 32'h108,       1'b0, W2,    32'h108,       1'b0, 1'b0));
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b1, 32'h40,       1'b0, 32'h108,       1'b1, W2,    32'h108,       1'b0, 1'b0)); // issue + redirect
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b1, 32'h2002,     1'b1, 32'h40,        1'b0, W2,    32'h108,       1'b0, 1'b0)); // drop set
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b1, 32'h3001,     1'b1, 32'h40,        1'b0, W2,    32'h108,       1'b0, 1'b0)); // newest wins
        vq.push_back(v(1'b1, BAD,   1'b1, 1'b0, 32'd0,        1'b1, 32'h40,        1'b0, W2,    32'h108,       1'b0, 1'b0)); // old ack discarded
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b0, 32'd0,        1'b1, 32'h3000,      1'b0, W2,    32'h108,       1'b0, 1'b0));
        vq.push_back(v(1'b1, EC,    1'b1, 1'b0, 32'd0,        1'b1, 32'h3000,      1'b0, W2,    32'h108,       1'b0, 1'b0));
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b1, 32'h500,      1'b0, 32'h3000,      1'b0, EC,    32'h3000,      1'b0, 1'b0)); // redirect beats halt
        vq.push_back(v(1'b1, W1,    1'b1, 1'b1, 32'h600,      1'b1, 32'h500,       1'b0, EC,    32'h3000,      1'b0, 1'b0)); // ack + redirect
        vq.push_back(v(1'b1, W2,    1'b1, 1'b0, 32'd0,        1'b1, 32'h600,       1'b0, EC,    32'h3000,      1'b0, 1'b0));
        vq.push_back(v(1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b0, 32'h600,       1'b0, W2,    32'h600,       1'b0, 1'b0));
        vq.push_back(v(1'b0, 32'd0, 1'b0, 1'b1, 32'h700,      1'b0, 32'h600,       1'b1, W2,    32'h600,       1'b0, 1'b0)); // squash
        vq.push_back(v(1'b1, EC,    1'b1, 1'b0, 32'd0,        1'b1, 32'h700,       1'b0, W2,    32'h600,       1'b0, 1'b0));
        vq.push_back(v(1'b0, 32'd0, 1'b1, 1'b0, 32'd0,        1'b0, 32'h700,       1'b0, EC,    32'h700,       1'b0, 1'b0)); // ECALL decode
        vq.push_back(v(1'b1, W0,    1'b1, 1'b1, 32'h800,      1'b0, 32'h700,       1'b0, EC,    32'h700,       1'b1, 1'b0)); // halted
        vq.push_back(v(1'b1, W0,    1'b1, 1'b1, 32'h800,      1'b0, 32'h700,       1'b0, EC,    32'h700,       1'b1, 1'b0));

        repeat (2) @(negedge clk);
        chk_all("rst", 1'b0, RPC, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            chk_all($sformatf("row%0d", i), vq[i].req, vq[i].addr, vq[i].valid,
                    vq[i].instr, vq[i].ipc, vq[i].halted, vq[i].illegal);
            drive(vq[i].ack, vq[i].rdata, vq[i].ready, vq[i].rv, vq[i].rpc);
        end

        // PC wrap: fetch at FFFF_FFFC, issue it, next fetch must be at 0.
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        chk_all("rst2", 1'b0, RPC, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        drive(1'b1, BAD,   1'b0, 1'b0, 32'd0);
        chk_all("wrap_f", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, W0,    1'b0, 1'b0, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_all("wrap_i", 1'b0, 32'hFFFF_FFFC, 1'b1, W0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_all("wrap_n", 1'b1, 32'h0, 1'b0, W0, 32'hFFFF_FFFC, 1'b0, 1'b0);

        // Asynchronous reset mid-request, then a late ack while in BOOT.
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 1'b0, RPC, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, W1, 1'b1, 1'b0, 32'd0);
        chk_all("late", 1'b1, RPC, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Illegal word halts with illegal=1; later acks and redirects are ignored.
        drive(1'b1, BAD,   1'b1, 1'b0, 32'd0);
        chk_all("ill_d", 1'b0, RPC, 1'b0, BAD, RPC, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_all("ill_h", 1'b0, RPC, 1'b0, BAD, RPC, 1'b1, 1'b1);
        drive(1'b1, W0,    1'b1, 1'b1, 32'h40);
        drive(1'b1, W0,    1'b1, 1'b1, 32'h80);
        chk_all("ill_s", 1'b0, RPC, 1'b0, BAD, RPC, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
